fifo_rd_stream: RTL and testbench

Read-side consumer for the async FIFO, in the `clk_rd` domain.
- Pops words from the FIFO read port and absorbs the memory's 1-cycle read latency with a 2-entry skid buffer.
- Presents the words downstream on a valid/ready stream, framed into bursts of `BURST_LEN` words with a last flag.
- Provides a graceful stop/start control and a delivered-word counter.

---
 rtl/fifo_rd_stream.sv | 61 ++++++
 tb/tb_fifo_rd_stream.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read-side consumer; pops fifo_rd_* through a 2-entry skid buffer onto out_* valid/ready bursts, with enable/stopped control and word_count
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  stopped,
  output logic [31:0]           word_count
);
  typedef enum logic [1:0] {RUN, STOPPING, STOPPED} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [2];
  logic head, tail, accept, land;
  logic [1:0] occ, inflight;
  logic [15:0] beat_cnt;
  assign accept     = out_valid & out_ready;
  assign land       = inflight[0];
  assign out_valid  = occ != 2'd0;
  assign out_data   = mem[head];
  assign out_last   = out_valid & (beat_cnt == 16'(BURST_LEN - 1));
  assign stopped    = state == STOPPED;
  assign fifo_rd_en = ~rst & (state == RUN) & ~fifo_empty &
                      (({1'b0, occ} + {1'b0, inflight} - {2'b0, accept}) < 3'd2);
  always_comb
    state_nx = enable ? RUN :
               ((state == STOPPING && inflight == 2'd0) || state == STOPPED) ? STOPPED : STOPPING;
  always_ff @(posedge clk_rd) begin
    if (rst) begin
      state      <= STOPPED;
      occ        <= 2'd0;
      inflight   <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      beat_cnt   <= 16'd0;
      word_count <= 32'd0;
    end else begin
      assert (!(land && !accept && occ == 2'd2));
      state    <= state_nx;
      inflight <= {1'b0, fifo_rd_en};
      occ      <= occ + {1'b0, land} - {1'b0, accept};
      if (land) begin
        mem[tail] <= fifo_rd_data;
        tail      <= ~tail;
      end
      if (accept) begin
        head       <= ~head;
        beat_cnt   <= out_last ? 16'd0 : beat_cnt + 16'd1;
        word_count <= word_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed self-checking bench for fifo_rd_stream against a registered-empty FIFO model
module tb_fifo_rd_stream;
  logic clk_rd = 1'b0;
  always #5 clk_rd = ~clk_rd;
  logic rst, enable, enable2, out_ready, out_ready2;
  logic fifo_empty = 1'b1, fifo_empty2 = 1'b1;
  logic fifo_rd_en, fifo_rd_en2, out_valid, out_valid2, out_last, out_last2, stopped, stopped2;
  logic [7:0] fifo_rd_data, fifo_rd_data2, out_data, out_data2;
  logic [31:0] word_count, word_count2;
  logic [7:0] mem [1024];
  int fill = 0, rd_ptr = 0, rd_empty_viol = 0, fill2 = 0, rd_ptr2 = 0;
  int total = 0, bad = 0, exp_idx = 0, lasts = 0, n2 = 0, lasts2 = 0, p;
  logic chk_en = 1'b0, held = 1'b0, hl;
  logic [7:0] hd;
  fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(16)) dut (
    .clk_rd(clk_rd), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .stopped(stopped), .word_count(word_count)
  );
  fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(1)) dut2 (
    .clk_rd(clk_rd), .rst(rst), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_rd_en(fifo_rd_en2), .fifo_rd_data(fifo_rd_data2), .out_valid(out_valid2),
    .out_data(out_data2), .out_last(out_last2), .out_ready(out_ready2),
    .stopped(stopped2), .word_count(word_count2)
  );
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && word_count < 32'(target); i++) begin
      @(posedge clk_rd);
      #1;
    end
    chk32("word_count_reach", word_count, 32'(target));
  endtask
  always @(posedge clk_rd) begin
    if (fifo_rd_en) begin
      if (fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
    fifo_empty <= rd_ptr + (fifo_rd_en ? 1 : 0) >= fill;
    if (fifo_rd_en2) begin
      fifo_rd_data2 <= 8'(rd_ptr2);
      rd_ptr2 <= rd_ptr2 + 1;
    end
    fifo_empty2 <= rd_ptr2 + (fifo_rd_en2 ? 1 : 0) >= fill2;
  end
  always @(negedge clk_rd) begin
    if (chk_en) begin
      chk1("occ_le_2", dut.occ <= 2'd2, 1'b1);
      if (held) begin
        chk1("stall_valid", out_valid, 1'b1);
        chk32("stall_data", 32'(out_data), 32'(hd));
        chk1("stall_last", out_last, hl);
      end
      if (out_valid && out_ready) begin
        chk32("order_data", 32'(out_data), 32'(exp_idx & 255));
        chk1("burst_last", out_last, exp_idx % 16 == 15);
        if (out_last) lasts++;
        exp_idx++;
      end
      held = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
    end
    if (!rst && out_valid2 && out_ready2) begin
      chk32("b1_data", 32'(out_data2), 32'(n2));
      chk1("b1_last", out_last2, 1'b1);
      if (out_last2) lasts2++;
      n2++;
    end
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; enable2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk_rd);
    @(negedge clk_rd);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_last", out_last, 1'b0);
    chk1("rst_rd_en", fifo_rd_en, 1'b0);
    chk1("rst_stopped", stopped, 1'b1);
    chk32("rst_count", word_count, 32'd0);
    fill = 64;
    @(posedge clk_rd);
    #1;
    rst = 1'b0; enable = 1'b1; out_ready = 1'b1; chk_en = 1'b1;
    @(posedge clk_rd);
    @(posedge clk_rd);
    @(negedge clk_rd);
    chk1("startup_not_valid", out_valid, 1'b0);
    chk1("startup_stopped", stopped, 1'b0);
    @(negedge clk_rd);
    chk1("first_valid", out_valid, 1'b1);
    chk32("first_data", 32'(out_data), 32'h0);
    for (int i = 0; i < 64; i++) begin
      chk1("stream_valid", out_valid, 1'b1);
      @(negedge clk_rd);
    end
    chk1("stream_done_valid", out_valid, 1'b0);
    chk32("stream_count", word_count, 32'd64);
    chk32("stream_lasts", lasts, 4);
    chk32("rd_while_empty", rd_empty_viol, 0);
    fill = 128;
    for (int i = 0; i < 2000 && word_count < 32'd128; i++) begin
      @(posedge clk_rd);
      #1;
      out_ready = $urandom_range(0, 9) < 7;
    end
    @(negedge clk_rd);
    chk32("random_count", word_count, 32'd128);
    @(posedge clk_rd);
    #1;
    out_ready = 1'b0; fill = 192; p = rd_ptr;
    repeat (10) @(posedge clk_rd);
    @(negedge clk_rd);
    chk32("stall_reads", rd_ptr - p, 2);
    chk1("stall_rd_en", fifo_rd_en, 1'b0);
    chk1("stall_head_valid", out_valid, 1'b1);
    chk32("stall_head_data", 32'(out_data), 32'h80);
    @(posedge clk_rd);
    #1;
    out_ready = 1'b1;
    run_until(160, 200);
    enable = 1'b0; p = rd_ptr;
    for (int i = 0; i < 6 && !stopped; i++) @(negedge clk_rd);
    chk1("stop_reached", stopped, 1'b1);
    repeat (4) @(negedge clk_rd);
    chk1("drain_valid", out_valid, 1'b0);
    chk32("drop_reads", rd_ptr - p, 1);
    chk32("drain_count", word_count, 32'(rd_ptr));
    chk1("stopped_rd_en", fifo_rd_en, 1'b0);
    @(posedge clk_rd);
    #1;
    enable = 1'b1;
    run_until(192, 200);
    fill2 = 5; enable2 = 1'b1;
    repeat (15) @(negedge clk_rd);
    chk32("b1_words", n2, 5);
    chk32("b1_lasts", lasts2, 5);
    chk32("b1_count", word_count2, 32'd5);
    fill = 256;
    run_until(200, 200);
    chk_en = 1'b0; rst = 1'b1;
    @(posedge clk_rd);
    @(negedge clk_rd);
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_last", out_last, 1'b0);
    chk32("mid_rst_count", word_count, 32'd0);
    chk1("mid_rst_stopped", stopped, 1'b1);
    chk1("mid_rst_rd_en", fifo_rd_en, 1'b0);
    @(posedge clk_rd);
    #1;
    rst = 1'b0; p = rd_ptr;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk_rd);
    chk1("post_rst_valid", out_valid, 1'b1);
    chk32("post_rst_data", 32'(out_data), 32'(p & 255));
    chk32("final_rd_while_empty", rd_empty_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
